glb_port_arbiter: RTL
=====================

# glb_port_arbiter

Shares the Global Buffer's single read port and single write port among `NUM_REQ` requesters, such as the GIN loader, the GON write-back path and the host/DMA loader. It sits between those requesters and the `GLB` instance in `Top`.
- Each port has independent round-robin arbitration, with optional locked bursts.
- The GLB pins are driven combinationally from the winning request.
- Read data is returned with a one-hot valid tag that is aligned to GLB read latency.

## Interface
- `NUM_REQ`, 4: number of requesters; 2..8.
- `ADDR_W`, 32: GLB byte-address width.
- `DATA_W`, 32: GLB data width.
- `RD_LAT`, 1: GLB cycles from `re` to valid `dout`; 1..3.

- `clk`  in  1  clock. All state updates on the rising edge.
- `rst`  in  1  reset. Asynchronous, active-high.
- `rd_req`  in  NUM_REQ  per-requester read request.
- `rd_lock`  in  NUM_REQ  per-requester read burst lock.
- `rd_addr`  in  NUM_REQ*ADDR_W  read addresses; requester i occupies slice [i*ADDR_W +: ADDR_W].
- `rd_gnt`  out  NUM_REQ  one-hot read grant, combinational.
- `rd_valid`  out  NUM_REQ  one-hot read-data tag.
- `rd_data`  out  DATA_W  read data, broadcast to all requesters; equals `glb_dout`.
- `wr_req`  in  NUM_REQ  per-requester write request.
- `wr_lock`  in  NUM_REQ  per-requester write burst lock.
- `wr_addr`  in  NUM_REQ*ADDR_W  write addresses, sliced as for `rd_addr`.
- `wr_data`  in  NUM_REQ*DATA_W  write data, sliced as for `rd_addr`.
- `wr_gnt`  out  NUM_REQ  one-hot write grant, combinational.
- `glb_re`  out  1  GLB read enable.
- `glb_r_addr`  out  ADDR_W  GLB read address.
- `glb_dout`  in  DATA_W  GLB read data.
- `glb_we`  out  1  GLB write enable.
- `glb_w_addr`  out  ADDR_W  GLB write address.
- `glb_din`  out  DATA_W  GLB write data.

## Operation
- The read and write ports use identical, independent arbiters. The rules below use the read names; the write arbiter substitutes the `wr_` signals.
- **Transfer:** a transfer occurs in any cycle where `rd_gnt[i]=1`. A requester holds `rd_req` and `rd_addr` until granted. The request for the next beat may be presented in the following cycle.
- **Arbiter state:** round-robin pointer `ptr` (0..NUM_REQ-1), FSM {ARB, LOCKED}, and register `owner`.
- **ARB state:**
  - The grant goes to the first requester with `rd_req=1`, searching from `ptr` upward with modulo wrap.
  - On a grant to requester k, `ptr` becomes (k+1) mod NUM_REQ.
  - If `rd_lock[k]=1` in the grant cycle, the FSM moves to LOCKED and `owner` becomes k.
- **LOCKED state:**
  - Only `owner` can be granted; other requesters are held off.
  - A grant to `owner` with `rd_lock=0` is the final beat, and the FSM returns to ARB.
  - `owner` with `rd_req=0` produces a bubble: no grant, and the FSM stays LOCKED.
  - `ptr` does not change while LOCKED.
- **GLB drive:**
  - `glb_re` = OR of `rd_gnt`.
  - `glb_r_addr` = the granted requester's address slice, or 0 when there is no grant.
  - The write side follows the same rule for `glb_we`, `glb_w_addr` and `glb_din`.
- **Read return:** an RD_LAT-deep shift register of one-hot tags is loaded with `rd_gnt` every cycle. `rd_valid` is the last stage of that register. `rd_data` is always `glb_dout`.
- **Read/write interaction:** the read and write ports may both grant in the same cycle. Same-address collisions are resolved by the GLB's write-first behaviour. The arbiter does not compare addresses.
- **Reset:**
  - Values: `ptr`=0, FSM=ARB, `owner`=0, tag pipeline cleared.
  - Outputs while `rst` is high: `rd_valid`=0, `rd_gnt`=0, `wr_gnt`=0, `glb_re`=0, `glb_we`=0, all `glb_*` address/data outputs 0.
  - Reset asserted mid-burst or with reads in flight discards the lock and the pending `rd_valid` tags. No stale valid appears after reset is released.

## Timing
- Request to grant: 0 cycles, combinational, when the requester wins.
- Grant to `rd_valid`/`rd_data`: exactly RD_LAT cycles.
- Throughput: one read and one write per cycle, sustained. Back-to-back grants to different requesters need no idle cycle.
- Worst-case wait in ARB for a continuously requesting requester: NUM_REQ-1 grants. A locked burst extends the wait by the burst length.
- The `ptr` and FSM update at the clock edge ending the grant cycle.

## Test plan
- **Single read, NUM_REQ=4, RD_LAT=1:** requester 2 reads addr 0x40 while the GLB holds 0xDEADBEEF there → `rd_gnt`=4'b0100 and `glb_r_addr`=0x40 in cycle 0; `rd_valid`=4'b0100 and `rd_data`=0xDEADBEEF in cycle 1.
- **Round-robin:** all 4 requesters assert `rd_req` continuously after reset → grants are 0,1,2,3,0,1 on consecutive cycles, with `glb_re` high every cycle.
- **Locked burst:**
  - Stimulus: requester 1 issues 3 beats with `rd_lock`=1,1,0 while requesters 0 and 3 request.
  - Required: grants go 1,1,1, then 3, then 0.
  - A 1-cycle `rd_req` drop by requester 1 mid-burst produces a bubble with no grant to 0 or 3.
- **Simultaneous read and write, same address:** requester 0 writes 0x1234 to 0x80 while requester 3 reads 0x80 in the same cycle → both grants are high and `rd_valid[3]` carries 0x1234 one cycle later.
- **Reset mid-operation:** `rst` is pulsed in the cycle after a read grant during a locked write burst → `rd_valid` stays 0 and the write FSM returns to ARB. The first grant after release goes to the lowest-index requester.
- **RD_LAT=3:** grants to requesters 0,1,2 on back-to-back cycles → `rd_valid` shows 0001, 0010, 0100 three cycles after each grant.

Source files
------------

// File: rtl/glb_port_arbiter.sv
// Round-robin read/write port sharing for the Global Buffer, with locked
// bursts and a latency-matched one-hot read-return tag.

module glb_rr_arb #(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] i_req,
  input  logic [N-1:0] i_lock,
  output logic [N-1:0] o_gnt
);
  localparam int PW = $clog2(N);

  typedef enum logic {ARB, LOCKED} state_t;

  state_t        r_state;
  state_t        w_state_nxt;
  logic [PW-1:0] r_ptr;
  logic [PW-1:0] w_ptr_nxt;
  logic [PW-1:0] r_owner;
  logic [PW-1:0] w_owner_nxt;
  logic [PW-1:0] w_k;
  logic [PW-1:0] w_idx;
  logic          w_hit;

  function automatic logic [PW-1:0] wrap_add(
    input logic [PW-1:0] a,
    input int            b
  );
    logic [PW:0] s;
    s = {1'b0, a} + (PW+1)'(b);
    if (s >= (PW+1)'(N)) s = s - (PW+1)'(N);
    return s[PW-1:0];
  endfunction

  // Scan downward so the last hit is the one nearest ptr.
  always_comb begin
    w_hit = 1'b0;
    w_k   = '0;
    w_idx = '0;
    if (r_state == LOCKED) begin
      w_hit = i_req[r_owner];
      w_k   = r_owner;
    end else begin
      for (int j = N-1; j >= 0; j--) begin
        w_idx = wrap_add(r_ptr, j);
        if (i_req[w_idx]) begin
          w_hit = 1'b1;
          w_k   = w_idx;
        end
      end
    end
  end

  always_comb begin
    o_gnt = '0;
    if (w_hit && !rst) o_gnt[w_k] = 1'b1;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_ptr_nxt   = r_ptr;
    w_owner_nxt = r_owner;
    if (w_hit) begin
      if (r_state == ARB) begin
        w_ptr_nxt = wrap_add(w_k, 1);
        if (i_lock[w_k]) begin
          w_state_nxt = LOCKED;
          w_owner_nxt = w_k;
        end
      end else if (!i_lock[r_owner]) begin
        w_state_nxt = ARB;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ARB;
      r_ptr   <= '0;
      r_owner <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_ptr   <= w_ptr_nxt;
      r_owner <= w_owner_nxt;
    end
  end
endmodule

module glb_port_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int RD_LAT  = 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        rd_req,
  input  logic [NUM_REQ-1:0]        rd_lock,
  input  logic [NUM_REQ*ADDR_W-1:0] rd_addr,
  output logic [NUM_REQ-1:0]        rd_gnt,
  output logic [NUM_REQ-1:0]        rd_valid,
  output logic [DATA_W-1:0]         rd_data,
  input  logic [NUM_REQ-1:0]        wr_req,
  input  logic [NUM_REQ-1:0]        wr_lock,
  input  logic [NUM_REQ*ADDR_W-1:0] wr_addr,
  input  logic [NUM_REQ*DATA_W-1:0] wr_data,
  output logic [NUM_REQ-1:0]        wr_gnt,
  output logic                      glb_re,
  output logic [ADDR_W-1:0]         glb_r_addr,
  input  logic [DATA_W-1:0]         glb_dout,
  output logic                      glb_we,
  output logic [ADDR_W-1:0]         glb_w_addr,
  output logic [DATA_W-1:0]         glb_din
);
  logic [NUM_REQ-1:0] r_tag [RD_LAT];

  glb_rr_arb #(.N(NUM_REQ)) u_rd_arb (
    .clk    (clk),
    .rst    (rst),
    .i_req  (rd_req),
    .i_lock (rd_lock),
    .o_gnt  (rd_gnt)
  );

  glb_rr_arb #(.N(NUM_REQ)) u_wr_arb (
    .clk    (clk),
    .rst    (rst),
    .i_req  (wr_req),
    .i_lock (wr_lock),
    .o_gnt  (wr_gnt)
  );

  // Grants are one-hot, so an OR of masked slices is the mux.
  always_comb begin
    glb_r_addr = '0;
    glb_w_addr = '0;
    glb_din    = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (rd_gnt[i]) glb_r_addr = glb_r_addr | rd_addr[i*ADDR_W +: ADDR_W];
      if (wr_gnt[i]) begin
        glb_w_addr = glb_w_addr | wr_addr[i*ADDR_W +: ADDR_W];
        glb_din    = glb_din    | wr_data[i*DATA_W +: DATA_W];
      end
    end
  end

  assign glb_re   = |rd_gnt;
  assign glb_we   = |wr_gnt;
  assign rd_data  = glb_dout;
  assign rd_valid = r_tag[RD_LAT-1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < RD_LAT; i++) r_tag[i] <= '0;
    end else begin
      r_tag[0] <= rd_gnt;
      for (int i = 1; i < RD_LAT; i++) r_tag[i] <= r_tag[i-1];
    end
  end
endmodule
